i2c_req_arbiter: RTL and testbench

Round-robin scheduler that shares one `i2c_controller` between `NUM_REQ` requesters. It latches a granted requester's address, direction and write byte, then sequences the controller's `new_data` / `bus_busy` / `done` handshake. It retries NACKed transfers, guards each attempt with a watchdog, and returns read data and status to the owning requester. It sits between the client blocks and the single `i2c_controller` instance, on the same 40 MHz system clock.

---
 rtl/i2c_req_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Latency: gnt one cycle after req is seen in IDLE, new_data one cycle later; rsp_valid one cycle after done rises.
// Backpressure: no grant while the controller reports bus_busy; losers keep req high and stay pending.
// Optional macro I2C_ARB_RETRY_EN compiles in the NACK retry counter and retry path.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 i2c_new_data,
  output logic [6:0]           i2c_addr,
  output logic                 i2c_rw,
  output logic [7:0]           i2c_data_in,
  input  logic [7:0]           i2c_data_out,
  input  logic                 i2c_bus_busy,
  input  logic                 i2c_ack_error,
  input  logic                 i2c_done
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               done_q;
  logic               done_rise;
  logic               retry_now;
  logic               found;
  logic [IDXW-1:0]    win;

  logic [NUM_REQ-1:0] gnt_d, rsp_valid_d;
  logic [7:0]         rsp_rdata_d, i2c_data_in_d;
  logic               rsp_err_d, rsp_timeout_d, i2c_new_data_d, i2c_rw_d;
  logic [6:0]         i2c_addr_d;

`ifdef I2C_ARB_RETRY_EN
  logic [2:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  assign done_rise = i2c_done && !done_q;

  // A NACKed completion is re-issued only while retries remain; timeouts never retry.
`ifdef I2C_ARB_RETRY_EN
  assign retry_now = i2c_ack_error && (retry_q < 3'(MAX_RETRY));
`else
  assign retry_now = 1'b0;
`endif

  // Round-robin search: first set req bit starting just above the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output logic; pulse outputs default low, latched fields hold.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    wd_d           = wd_q;
    gnt_d          = '0;
    rsp_valid_d    = '0;
    rsp_rdata_d    = rsp_rdata;
    rsp_err_d      = rsp_err;
    rsp_timeout_d  = rsp_timeout;
    i2c_new_data_d = 1'b0;
    i2c_addr_d     = i2c_addr;
    i2c_rw_d       = i2c_rw;
    i2c_data_in_d  = i2c_data_in;
`ifdef I2C_ARB_RETRY_EN
    retry_d        = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (!i2c_bus_busy && found) begin
          ptr_d         = win;
          gnt_d         = NUM_REQ'(1) << win;
          i2c_addr_d    = req_addr[7*win +: 7];
          i2c_rw_d      = req_rw[win];
          i2c_data_in_d = req_wdata[8*win +: 8];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        i2c_new_data_d = 1'b1;
        wd_d           = '0;
        state_d        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_q == WD_LAST) begin
          rsp_valid_d   = NUM_REQ'(1) << ptr_q;
          rsp_rdata_d   = 8'h00;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
          if (i2c_bus_busy) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          if (retry_now) begin
`ifdef I2C_ARB_RETRY_EN
            retry_d = retry_q + 3'd1;
`endif
            state_d = ISSUE;
          end else begin
            rsp_valid_d   = NUM_REQ'(1) << ptr_q;
            rsp_rdata_d   = i2c_rw ? i2c_data_out : 8'h00;
            rsp_err_d     = i2c_ack_error;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end
        end else if (wd_q == WD_LAST) begin
          rsp_valid_d   = NUM_REQ'(1) << ptr_q;
          rsp_rdata_d   = 8'h00;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        rsp_rdata_d   = 8'h00;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
`ifdef I2C_ARB_RETRY_EN
        retry_d       = 3'd0;
`endif
        state_d       = i2c_bus_busy ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!i2c_bus_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, watchdog and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDXW'(NUM_REQ - 1);
      wd_q         <= '0;
      done_q       <= 1'b0;
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
      i2c_new_data <= 1'b0;
      i2c_addr     <= 7'h00;
      i2c_rw       <= 1'b0;
      i2c_data_in  <= 8'h00;
`ifdef I2C_ARB_RETRY_EN
      retry_q      <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      done_q       <= i2c_done;
      gnt          <= gnt_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
      rsp_timeout  <= rsp_timeout_d;
      i2c_new_data <= i2c_new_data_d;
      i2c_addr     <= i2c_addr_d;
      i2c_rw       <= i2c_rw_d;
      i2c_data_in  <= i2c_data_in_d;
`ifdef I2C_ARB_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus randomized requesters and controller model.
// Transactions are scored against a round-robin / per-transaction reference model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_i2c_req_arbiter;
  localparam int N    = 4;
  localparam int MAXR = 2;
  localparam int TO   = 500;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0]   req_rw = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_err, rsp_timeout;
  logic           i2c_new_data, i2c_rw;
  logic [6:0]     i2c_addr;
  logic [7:0]     i2c_data_in;
  logic [7:0]     i2c_data_out = 8'h00;
  logic           i2c_bus_busy = 1'b0, i2c_ack_error = 1'b0, i2c_done = 1'b0;

  i2c_req_arbiter #(.NUM_REQ(N), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .i2c_new_data(i2c_new_data),
    .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_in(i2c_data_in),
    .i2c_data_out(i2c_data_out), .i2c_bus_busy(i2c_bus_busy),
    .i2c_ack_error(i2c_ack_error), .i2c_done(i2c_done)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model state
  bit         hang = 1'b0;
  bit         rdata_fixed = 1'b0;
  logic [7:0] fixed_rdata = 8'h00;
  int         len_min = 2, len_max = 10, tail_max = 3;
  int         ctl_cnt = 0, ctl_tail = 0;
  bit         ctl_nack = 1'b0;
  logic [7:0] ctl_rdata = 8'h00;
  bit         rand_en = 1'b0;

  // Reference-model / monitor state
  int         cyc = 0;
  logic [N-1:0]   req_last = '0, rw_last = '0;
  logic [7*N-1:0] addr_last = '0;
  logic [8*N-1:0] wd_last = '0;
  logic       busy_last = 1'b0;
  int         rr_last = N - 1;
  bit         outst = 1'b0;
  bit         o_hang = 1'b0;
  int         o_owner = 0, o_nd = 0, o_gcyc = 0;
  logic [6:0] o_addr = 7'h00;
  logic       o_rw = 1'b0;
  int         nd_count = 0, rsp_count = 0, nd_exp_cyc = -1;
  int         gnt_log[$];
  int         last_owner = -1, last_attempts = 0, last_delay = 0;
  logic [7:0] last_rdata = 8'h00;
  logic       last_err = 1'b0, last_to = 1'b0;

  task automatic ctl_step();
    if (i2c_done) begin
      i2c_done      = 1'b0;
      i2c_ack_error = 1'b0;
    end
    if (i2c_new_data) begin
      i2c_bus_busy = 1'b1;
      ctl_tail     = 0;
      if (hang) ctl_cnt = 0;
      else begin
        ctl_cnt   = $urandom_range(len_max, len_min);
        ctl_nack  = (i2c_addr == 7'h12);
        ctl_rdata = rdata_fixed ? fixed_rdata : 8'($urandom);
      end
    end else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        i2c_done      = 1'b1;
        i2c_ack_error = ctl_nack;
        i2c_data_out  = ctl_rdata;
        ctl_tail      = $urandom_range(tail_max, 0);
        if (ctl_tail == 0) i2c_bus_busy = 1'b0;
      end
    end else if (ctl_tail > 0) begin
      ctl_tail--;
      if (ctl_tail == 0) i2c_bus_busy = 1'b0;
    end
  endtask

  task automatic raise(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req[i]             = 1'b1;
    req_addr[7*i +: 7] = a;
    req_rw[i]          = rw;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (gnt[i]) req[i] = 1'b0;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(9, 0) == 0)
          raise(i, ($urandom_range(5, 0) == 0) ? 7'h12 : 7'($urandom),
                1'($urandom), 8'($urandom));
      end
    end
    ctl_step();
  endtask

  task automatic wait_rsp(input int n, input int bound, input string tag);
    int t = 0;
    while (rsp_count < n && t < bound) begin tick(); t++; end
    check(tag, rsp_count >= n, 1);
  endtask

  task automatic wait_gnts(input int n, input int bound, input string tag);
    int t = 0;
    while (gnt_log.size() < n && t < bound) begin tick(); t++; end
    check(tag, gnt_log.size() >= n, 1);
  endtask

  // Monitor and scoreboard on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (cyc == nd_exp_cyc) check("new_data_after_gnt", i2c_new_data, 1);
      if (i2c_new_data) nd_count++;
      if (gnt != '0) begin
        int exp_w;
        exp_w = -1;
        for (int k = 1; k <= N; k++)
          if (exp_w < 0 && req_last[(rr_last + k) % N]) exp_w = (rr_last + k) % N;
        check("gnt_onehot", $countones(gnt), 1);
        check("gnt_bus_idle", busy_last, 0);
        check("gnt_no_outstanding", outst, 0);
        check("gnt_winner", gnt, (exp_w < 0) ? 0 : (1 << exp_w));
        if (exp_w >= 0) begin
          check("gnt_addr", i2c_addr, addr_last[7*exp_w +: 7]);
          check("gnt_rw", i2c_rw, rw_last[exp_w]);
          check("gnt_wdata", i2c_data_in, wd_last[8*exp_w +: 8]);
          rr_last    = exp_w;
          gnt_log.push_back(exp_w);
          outst      = 1'b1;
          o_owner    = exp_w;
          o_addr     = addr_last[7*exp_w +: 7];
          o_rw       = rw_last[exp_w];
          o_hang     = hang;
          o_nd       = nd_count;
          o_gcyc     = cyc;
          nd_exp_cyc = cyc + 1;
        end
      end
      if (rsp_valid != '0) begin
        check("rsp_expected", outst, 1);
        if (outst) begin
          bit exp_nack;
          int exp_att;
          exp_nack = (o_addr == 7'h12) && !o_hang;
          exp_att  = (exp_nack && RETRY_ON) ? MAXR + 1 : 1;
          check("rsp_owner", rsp_valid, 1 << o_owner);
          check("rsp_attempts", nd_count - o_nd, exp_att);
          check("rsp_err", rsp_err, exp_nack || o_hang);
          check("rsp_timeout", rsp_timeout, o_hang);
          if (o_hang) check("timeout_latency", cyc - o_gcyc, TO + 1);
          else check("rsp_rdata", rsp_rdata, o_rw ? ctl_rdata : 8'h00);
          last_owner    = o_owner;
          last_attempts = nd_count - o_nd;
          last_delay    = cyc - o_gcyc;
          last_rdata    = rsp_rdata;
          last_err      = rsp_err;
          last_to       = rsp_timeout;
          outst         = 1'b0;
          rsp_count++;
        end
      end
    end
    req_last  = req;
    rw_last   = req_rw;
    addr_last = req_addr;
    wd_last   = req_wdata;
    busy_last = i2c_bus_busy;
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not end, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bg, br, bn;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_outputs", {gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
    check("reset_i2c_outputs", {i2c_new_data, i2c_addr, i2c_rw, i2c_data_in}, 0);
    rst_n = 1'b1;
    tick();

    // Fairness: 0,1,3 requested together, then 0 and 1 re-raised while 3 is in flight
    len_min = 20; len_max = 20;
    bg = gnt_log.size(); br = rsp_count;
    raise(0, 7'h6D, 0, 8'h11); raise(1, 7'h6D, 0, 8'h22); raise(3, 7'h6D, 0, 8'h33);
    wait_gnts(bg + 3, 400, "fair_first_three");
    check("fair_g0", gnt_log[bg], 0);
    check("fair_g1", gnt_log[bg + 1], 1);
    check("fair_g2", gnt_log[bg + 2], 3);
    raise(0, 7'h6D, 1, 8'h44); raise(1, 7'h6D, 0, 8'h55);
    wait_gnts(bg + 5, 400, "fair_next_two");
    check("fair_g3", gnt_log[bg + 3], 0);
    check("fair_g4", gnt_log[bg + 4], 1);
    wait_rsp(br + 5, 400, "fair_all_rsp");
    len_min = 2; len_max = 10;
    repeat (8) tick();

    // Single write
    bg = gnt_log.size(); br = rsp_count; bn = nd_count;
    raise(0, 7'h6D, 0, 8'hA5);
    wait_rsp(br + 1, 200, "wr_rsp_seen");
    check("wr_gnt_count", gnt_log.size() - bg, 1);
    check("wr_newdata_count", nd_count - bn, 1);
    check("wr_owner", last_owner, 0);
    check("wr_err", last_err, 0);
    check("wr_rdata", last_rdata, 8'h00);
    repeat (8) tick();

    // Read returning 8'h8C
    rdata_fixed = 1'b1; fixed_rdata = 8'h8C;
    br = rsp_count;
    raise(2, 7'h6D, 1, 8'h00);
    wait_rsp(br + 1, 200, "rd_rsp_seen");
    check("rd_owner", last_owner, 2);
    check("rd_rdata", last_rdata, 8'h8C);
    check("rd_err", last_err, 0);
    rdata_fixed = 1'b0;
    repeat (8) tick();

    // NACK with retries
    bg = gnt_log.size(); br = rsp_count;
    raise(0, 7'h12, 0, 8'h3C);
    wait_rsp(br + 1, 300, "nack_rsp_seen");
    check("nack_attempts", last_attempts, RETRY_ON ? 3 : 1);
    check("nack_gnt_count", gnt_log.size() - bg, 1);
    check("nack_err", last_err, 1);
    check("nack_timeout", last_to, 0);
    repeat (8) tick();

    // Watchdog timeout, then DRAIN holds off the next grant
    hang = 1'b1;
    bg = gnt_log.size(); br = rsp_count;
    raise(1, 7'h6D, 0, 8'h77);
    wait_rsp(br + 1, 700, "to_rsp_seen");
    check("to_err", last_err, 1);
    check("to_timeout", last_to, 1);
    check("to_delay", last_delay, TO + 1);
    raise(2, 7'h6D, 0, 8'h88);
    repeat (30) tick();
    check("drain_no_gnt", gnt_log.size() - bg, 1);
    hang = 1'b0;
    i2c_bus_busy = 1'b0;
    wait_rsp(br + 2, 200, "drain_rsp_seen");
    check("drain_gnt_count", gnt_log.size() - bg, 2);
    check("drain_owner", last_owner, 2);
    repeat (8) tick();

    // Asynchronous reset in WAIT_DONE
    len_min = 40; len_max = 40;
    bg = gnt_log.size();
    raise(0, 7'h6D, 0, 8'h99);
    wait_gnts(bg + 1, 100, "rst_first_gnt");
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_outputs", {gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
    check("rst_mid_i2c_outputs", {i2c_new_data, i2c_addr, i2c_rw, i2c_data_in}, 0);
    outst = 1'b0; rr_last = N - 1; nd_exp_cyc = -1;
    br = rsp_count; bg = gnt_log.size();
    raise(1, 7'h6D, 0, 8'h5A);
    repeat (2) tick();
    rst_n = 1'b1;
    len_min = 2; len_max = 10;
    wait_gnts(bg + 1, 200, "rst_req1_gnt");
    check("rst_no_rsp", rsp_count - br, 0);
    check("rst_gnt_who", gnt_log[bg], 1);
    wait_rsp(br + 1, 200, "rst_req1_rsp");
    check("rst_req1_owner", last_owner, 1);
    repeat (8) tick();

    // Randomized traffic
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    begin
      int t = 0;
      while ((outst || req != '0) && t < 2000) begin tick(); t++; end
      check("random_drained", outst || req != '0, 0);
    end
    check("random_activity", rsp_count > 40, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
